// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, action codes, deframer states and the key map.
package ps2_pkg;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F3    = 8'h04;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int unsigned ACT_NONE     = 0;
  localparam int unsigned ACT_P1_LIGHT = 1;
  localparam int unsigned ACT_P1_HEAVY = 2;
  localparam int unsigned ACT_SPACE    = 3;
  localparam int unsigned ACT_P2_LEFT  = 4;
  localparam int unsigned ACT_P2_RIGHT = 5;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // Extended codes never map to an action; unknown codes map to ACT_NONE.
  function automatic int unsigned map_scan(input logic [7:0] code, input logic ext);
    int unsigned act;
    act = ACT_NONE;
    if (!ext) begin
      case (code)
        SC_A:     act = ACT_P1_LIGHT;
        SC_D:     act = ACT_P1_HEAVY;
        SC_SPACE: act = ACT_SPACE;
        SC_F1:    act = ACT_P2_LEFT;
        SC_F3:    act = ACT_P2_RIGHT;
        default:  act = ACT_NONE;
      endcase
    end
    return act;
  endfunction

endpackage

// File: rtl/action_fifo.sv
// Small circular FIFO with synchronous reset and a flush that empties it every cycle it is held.
module action_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, pop_eff, push_eff;

  assign empty    = (count_q == '0);
  assign full_o   = (count_q == CntW'(Depth));
  assign valid_o  = ~empty;
  assign pop_eff  = pop_i & ~empty & ~flush_i;
  // A pop frees a slot in the same cycle, so push at full is accepted when popping.
  assign push_eff = push_i & ~flush_i & (~full_o | pop_eff);
  assign drop_o   = push_i & ~flush_i & full_o & ~pop_eff;
  assign data_o   = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_eff) - CntW'(pop_eff);
    end
  end

  // Storage; contents are masked by the empty check so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_action_receiver.sv
// System-clocked PS/2 receiver: synchronise, deframe, decode prefixes, map keys, queue actions.
module ps2_action_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACTION_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ps2_clk,
  input  logic                i_ps2_data,
  input  logic                i_round_start,
  input  logic                i_action_ready,
  output logic [ACTION_W-1:0] o_action,
  output logic                o_action_release,
  output logic                o_action_valid,
  output logic                o_frame_err,
  output logic                o_overflow,
  output logic [7:0]          o_scan_code
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimeoutMax = TimerW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] ps2_clk_sync_q, ps2_data_sync_q;
  logic                   ps2_fall, ps2_bit;

  ps2_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;
  logic              good_q, good_d;
  logic [7:0]        byte_q, byte_d;

  logic [7:0]          scan_code_q, scan_code_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic                overflow_q, overflow_d;
  logic [ACTION_W-1:0] act;
  logic                push_req;

  logic [ACTION_W:0] fifo_data;
  logic              fifo_full, fifo_drop;

  // Line synchronisers; reloading to 1 on reset keeps a held-low line from looking like an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ps2_clk_sync_q  <= '1;
      ps2_data_sync_q <= '1;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
      ps2_data_sync_q <= {ps2_data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign ps2_fall = ps2_clk_sync_q[SYNC_STAGES-1] & ~ps2_clk_sync_q[SYNC_STAGES-2];
  assign ps2_bit  = ps2_data_sync_q[SYNC_STAGES-1];

  // Deframer and timeout state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      good_q    <= 1'b0;
      byte_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      good_q    <= good_d;
      byte_q    <= byte_d;
    end
  end

  // Deframer next state: one step per PS/2 falling edge, aborted by the idle-line timer.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    err_d     = 1'b0;
    good_d    = 1'b0;
    byte_d    = byte_q;

    if (ps2_fall || state_q == StIdle) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    if (ps2_fall) begin
      unique case (state_q)
        StIdle: begin
          if (!ps2_bit) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        StData: begin
          shift_d = {ps2_bit, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StParity: begin
          parity_d = ps2_bit;
          state_d  = StStop;
        end
        StStop: begin
          if (ps2_bit && (^{shift_q, parity_q})) begin
            good_d = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      endcase
    end else if (state_q != StIdle && timer_q == TimeoutMax) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      timer_d   = '0;
      err_d     = 1'b1;
    end
  end

  // Byte decode registers: prefix flags, debug scan code and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_code_q <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      scan_code_q <= scan_code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      overflow_q  <= overflow_d;
    end
  end

  // Good-byte handling: prefixes only set flags, any other byte is mapped and clears them.
  always_comb begin
    scan_code_d = scan_code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    act         = '0;
    if (good_q) begin
      scan_code_d = byte_q;
      if (byte_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        act   = ACTION_W'(map_scan(byte_q, ext_q));
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign push_req   = good_q & (act != '0) & i_round_start;
  assign overflow_d = overflow_q | fifo_drop;

  action_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(ACTION_W + 1)
  ) u_action_fifo (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .flush_i(~i_round_start),
    .push_i (push_req),
    .pop_i  (i_action_ready),
    .data_i ({brk_q, act}),
    .data_o (fifo_data),
    .valid_o(o_action_valid),
    .full_o (fifo_full),
    .drop_o (fifo_drop)
  );

  assign o_action         = fifo_data[ACTION_W-1:0];
  assign o_action_release = fifo_data[ACTION_W];
  assign o_frame_err      = err_q;
  assign o_overflow       = overflow_q;
  assign o_scan_code      = scan_code_q;

  // Full is implied by drop; kept visible for debug probing.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_action_receiver.sv
// Directed bench: table of key frames plus hand sequences for errors, timeout, overflow, flush.
module tb_ps2_action_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       round_start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] action;
  logic       release_o, valid, frame_err, overflow;
  logic [7:0] scan_code;

  int passed = 0;
  int total  = 0;
  int err_seen = 0;
  int err_long = 0;
  logic err_prev = 1'b0;

  ps2_action_receiver #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(50),
    .FIFO_DEPTH (4),
    .ACTION_W   (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ps2_clk       (ps2_clk),
    .i_ps2_data      (ps2_data),
    .i_round_start   (round_start),
    .i_action_ready  (ready),
    .o_action        (action),
    .o_action_release(release_o),
    .o_action_valid  (valid),
    .o_frame_err     (frame_err),
    .o_overflow      (overflow),
    .o_scan_code     (scan_code)
  );

  always #5 clk = ~clk;

  // Count error pulses and any pulse that lasts more than one cycle.
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (frame_err && err_prev) err_long++;
    err_prev = frame_err;
  end

  typedef struct {
    logic [7:0] prefix;
    logic [7:0] code;
    logic       exp_valid;
    logic [3:0] exp_act;
    logic       exp_rel;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(5);
    ps2_clk = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip);
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(5);
  endtask

  // Like send_frame, but raises ready for exactly the cycle in which the byte is pushed.
  task automatic send_frame_pop(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    ps2_data = 1'b1;
    tick(5);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic pop_one(input string name, input logic [3:0] exp_act);
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_act"}, 32'(action), 32'(exp_act));
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    int e0;
    vecs[0] = '{8'h00, 8'h1C, 1'b1, 4'd1, 1'b0};
    vecs[1] = '{8'hF0, 8'h23, 1'b1, 4'd2, 1'b1};
    vecs[2] = '{8'h00, 8'h29, 1'b1, 4'd3, 1'b0};
    vecs[3] = '{8'h00, 8'h05, 1'b1, 4'd4, 1'b0};
    vecs[4] = '{8'hF0, 8'h04, 1'b1, 4'd5, 1'b1};
    vecs[5] = '{8'hE0, 8'h1C, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{8'h00, 8'h12, 1'b0, 4'd0, 1'b0};

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_action", 32'(action), 32'd0);
    check("rst_release", 32'(release_o), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_scan", 32'(scan_code), 32'd0);

    round_start = 1'b1;
    tick(2);
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].prefix != 8'h00) begin
        send_frame(vecs[v].prefix, 1'b0);
        check($sformatf("v%0d_prefix_no_entry", v), 32'(valid), 32'd0);
      end
      send_frame(vecs[v].code, 1'b0);
      check($sformatf("v%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d_act", v), 32'(action), 32'(vecs[v].exp_act));
      check($sformatf("v%0d_rel", v), 32'(release_o), 32'(vecs[v].exp_rel));
      check($sformatf("v%0d_scan", v), 32'(scan_code), 32'(vecs[v].code));
      if (vecs[v].exp_valid) begin
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check($sformatf("v%0d_popped", v), 32'(valid), 32'd0);
      end
    end
    check("table_no_err", 32'(err_seen), 32'd0);

    // Bad parity: one single-cycle error, nothing queued, scan code holds.
    e0 = err_seen;
    send_frame(8'h1C, 1'b1);
    check("parity_err_count", 32'(err_seen - e0), 32'd1);
    check("parity_err_width", 32'(err_long), 32'd0);
    check("parity_valid", 32'(valid), 32'd0);
    check("parity_scan_hold", 32'(scan_code), 32'h12);

    // Timeout after four data bits, then a good frame decodes normally.
    e0 = err_seen;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    tick(60);
    check("timeout_err", 32'(err_seen - e0), 32'd1);
    send_frame(8'h29, 1'b0);
    check("after_timeout_valid", 32'(valid), 32'd1);
    check("after_timeout_act", 32'(action), 32'd3);
    check("after_timeout_scan", 32'(scan_code), 32'h29);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;

    // Overflow: five keys into a four-deep FIFO with no consumer.
    send_frame(8'h1C, 1'b0);
    send_frame(8'h23, 1'b0);
    send_frame(8'h29, 1'b0);
    send_frame(8'h05, 1'b0);
    check("full_no_overflow_yet", 32'(overflow), 32'd0);
    send_frame(8'h04, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("full_head", 32'(action), 32'd1);
    send_frame_pop(8'h05);
    pop_one("q0", 4'd2);
    pop_one("q1", 4'd3);
    pop_one("q2", 4'd4);
    pop_one("q3", 4'd4);
    check("drained", 32'(valid), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Round gating and flush.
    round_start = 1'b0;
    send_frame(8'h1C, 1'b0);
    check("round_off_no_entry", 32'(valid), 32'd0);
    round_start = 1'b1;
    tick(1);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h23, 1'b0);
    check("two_queued", 32'(valid), 32'd1);
    round_start = 1'b0;
    tick(1);
    check("flush_next_cycle", 32'(valid), 32'd0);
    round_start = 1'b1;
    tick(2);
    check("flush_stays_empty", 32'(valid), 32'd0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("ext_no_action", 32'(valid), 32'd0);

    // Reset mid-frame must restart the deframer cleanly.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("midrst_overflow_clr", 32'(overflow), 32'd0);
    send_frame(8'h1C, 1'b0);
    check("midrst_valid", 32'(valid), 32'd1);
    check("midrst_act", 32'(action), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_action_receiver.md
Name: ps2_action_receiver

Overview:
- System-clocked PS/2 keyboard receiver that replaces direct sampling on the keyboard clock edge.
- Synchronises the PS/2 clock and data lines and deframes 11-bit frames with start, parity and stop checks.
- Tracks break (F0) and extended (E0) prefixes and maps scan codes to player action codes.
- Buffers actions in a small FIFO with a valid/ready handshake toward the game logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for i_ps2_clk and i_ps2_data (minimum 2).
- TIMEOUT_CYC, 100000, system cycles without a PS/2 falling edge before an in-progress frame is aborted.
- FIFO_DEPTH, 4, action FIFO entries (power of two, minimum 2).
- ACTION_W, 4, width of the action code.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_ps2_clk  in  1  raw keyboard clock, asynchronous.
- i_ps2_data  in  1  raw keyboard data, asynchronous.
- i_round_start  in  1  high enables action capture; low flushes the FIFO and blocks pushes.
- i_action_ready  in  1  consumer accepts the head entry.
- o_action  out  ACTION_W  head action code; 0 when the FIFO is empty.
- o_action_release  out  1  head entry is a key release (break).
- o_action_valid  out  1  FIFO is non-empty.
- o_frame_err  out  1  one-cycle pulse on bad start, parity, stop or timeout.
- o_overflow  out  1  sticky; set when a push is dropped, cleared only by i_rst.
- o_scan_code  out  8  last good data byte (debug).

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, prefix flags cleared.
- Synchroniser: SYNC_STAGES flops per line, reset to 1.
- Edge detect: a PS/2 falling edge is synced clock 1 -> 0 between consecutive stages; all data sampling uses the synced data at that edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge, data=0 moves to DATA with bit count 0. Data=1 stays in IDLE and pulses o_frame_err.
  - DATA: shift in LSB first, 8 edges, then move to PARITY.
  - PARITY: capture the bit, then move to STOP.
  - STOP: a frame is good when the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Otherwise pulse o_frame_err. Always return to IDLE.
- Timeout: the counter resets on every falling edge and counts only outside IDLE. Reaching TIMEOUT_CYC-1 returns to IDLE, pulses o_frame_err and discards the partial byte.
- Good byte handling, one cycle after the STOP edge:
  - o_scan_code <= byte.
  - E0 sets the ext flag; F0 sets the brk flag; neither produces an action.
  - Any other byte: map it, then clear both flags.
- Scan code map (ext=0):
  - 1C -> 1
  - 23 -> 2
  - 29 -> 3
  - 05 -> 4
  - 04 -> 5
  - Any other code, or ext=1 -> no action.
- Push: occurs when the map hits, i_round_start=1 and the FIFO is not full. The entry is {brk, code}. If the FIFO is full, drop the entry and set o_overflow.
- Pop: occurs when o_action_valid and i_action_ready are both high.
  - Push and pop in the same cycle are legal at any occupancy, including full, where the occupancy stays at FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.
- Latency: stop-bit edge detected at cycle N; push at N+1; o_action_valid high at N+2 when the FIFO was empty.
- i_round_start low: pointers and count clear every cycle and o_action_valid goes to 0. The deframer and prefix flags keep running.
- i_rst mid-frame: returns to IDLE on the next clock. The synchronisers reload to 1 so no spurious edge is seen.

Decomposition:
- Shared package ps2_pkg holds:
  - Scan constants: SC_A=8'h1C, SC_D=8'h23, SC_SPACE=8'h29, SC_F1=8'h05, SC_F3=8'h04, SC_BREAK=8'hF0, SC_EXT=8'hE0.
  - Action codes: ACT_NONE=0, ACT_P1_LIGHT=1, ACT_P1_HEAVY=2, ACT_SPACE=3, ACT_P2_LEFT=4, ACT_P2_RIGHT=5.
  - Deframer state enum.
- One sub-module, action_fifo (parametrised depth/width, synchronous reset plus a flush input). Everything else stays in the top module.

Test Plan:
- Round enabled, send frame 1C (parity 0, stop 1), i_action_ready=0 -> o_action_valid=1, o_action=1, o_action_release=0; o_scan_code=8'h1C.
- Send F0 then 23 -> one entry with o_action=2, o_action_release=1; F0 alone produces no entry.
- Send 1C with a flipped parity bit -> o_frame_err pulses for exactly 1 cycle; FIFO stays empty; o_scan_code unchanged.
- Stop PS/2 clock after 4 data bits for TIMEOUT_CYC cycles (set to 50 in test) -> o_frame_err pulses; a following good 29 frame yields o_action=3.
- i_action_ready=0, send 5 valid keys with FIFO_DEPTH=4 -> 4 entries held in order, o_overflow=1. Then pop while pushing 05 at full -> count stays 4 and the new tail is 4.
- With i_round_start=0, send 1C -> no entry. Raise i_round_start with 2 entries queued, then drop it -> o_action_valid=0 on the next cycle. Send E0,1C -> no action.
